// File: rtl/mux4a2_cond_l1.sv
// Layer-1 4-to-2 mux: captures a 4-lane word every two cycles and emits lanes 0/1, then lanes 2/3.
// Optional per-lane parity outputs are enabled by defining MUXL1_PARITY_EN.
module mux4a2_cond_l1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_in0,
    input  logic             valid_in1,
    input  logic             valid_in2,
    input  logic             valid_in3,
    input  logic [WIDTH-1:0] data_in0_muxL1,
    input  logic [WIDTH-1:0] data_in1_muxL1,
    input  logic [WIDTH-1:0] data_in2_muxL1,
    input  logic [WIDTH-1:0] data_in3_muxL1,
    output logic             in_ready,
    output logic             selectorL1,
    output logic             validout0,
    output logic             validout1,
`ifdef MUXL1_PARITY_EN
    output logic             parityout0,
    output logic             parityout1,
`endif
    output logic [WIDTH-1:0] dataout0_muxL1,
    output logic [WIDTH-1:0] dataout1_muxL1
);

    typedef enum logic {
        PH_CAPTURE = 1'b0,
        PH_DRAIN   = 1'b1
    } phase_t;

    // Even parity of one lane value
    function automatic logic parity_f(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    phase_t           r_phase;
    logic [WIDTH-1:0] r_hold2;
    logic [WIDTH-1:0] r_hold3;
    logic             r_hold_v2;
    logic             r_hold_v3;

    phase_t           w_nxt_phase;
    logic             w_nxt_sel;
    logic             w_nxt_v0;
    logic             w_nxt_v1;
    logic [WIDTH-1:0] w_nxt_d0;
    logic [WIDTH-1:0] w_nxt_d1;

    assign in_ready = (r_phase == PH_CAPTURE) & reset_L;

    // Next-state selection: capture slot forwards lanes 0/1, drain slot replays the held lanes 2/3
    always_comb begin
        w_nxt_phase = PH_CAPTURE;
        w_nxt_sel   = 1'b0;
        w_nxt_v0    = 1'b0;
        w_nxt_v1    = 1'b0;
        w_nxt_d0    = dataout0_muxL1;
        w_nxt_d1    = dataout1_muxL1;
        case (r_phase)
            PH_CAPTURE: begin
                w_nxt_phase = PH_DRAIN;
                w_nxt_sel   = 1'b0;
                w_nxt_v0    = valid_in0;
                w_nxt_v1    = valid_in1;
                if (valid_in0) begin
                    w_nxt_d0 = data_in0_muxL1;
                end else begin
                    w_nxt_d0 = dataout0_muxL1;
                end
                if (valid_in1) begin
                    w_nxt_d1 = data_in1_muxL1;
                end else begin
                    w_nxt_d1 = dataout1_muxL1;
                end
            end
            PH_DRAIN: begin
                w_nxt_phase = PH_CAPTURE;
                w_nxt_sel   = 1'b1;
                w_nxt_v0    = r_hold_v2;
                w_nxt_v1    = r_hold_v3;
                if (r_hold_v2) begin
                    w_nxt_d0 = r_hold2;
                end else begin
                    w_nxt_d0 = dataout0_muxL1;
                end
                if (r_hold_v3) begin
                    w_nxt_d1 = r_hold3;
                end else begin
                    w_nxt_d1 = dataout1_muxL1;
                end
            end
            default: begin
                w_nxt_phase = PH_CAPTURE;
                w_nxt_sel   = 1'b0;
                w_nxt_v0    = 1'b0;
                w_nxt_v1    = 1'b0;
                w_nxt_d0    = dataout0_muxL1;
                w_nxt_d1    = dataout1_muxL1;
            end
        endcase
    end

    // Phase flop, lane 2/3 hold registers (loaded only in capture) and registered outputs
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_phase        <= PH_CAPTURE;
            r_hold2        <= {WIDTH{1'b0}};
            r_hold3        <= {WIDTH{1'b0}};
            r_hold_v2      <= 1'b0;
            r_hold_v3      <= 1'b0;
            selectorL1     <= 1'b0;
            validout0      <= 1'b0;
            validout1      <= 1'b0;
            dataout0_muxL1 <= {WIDTH{1'b0}};
            dataout1_muxL1 <= {WIDTH{1'b0}};
        end else begin
            if (r_phase == PH_CAPTURE) begin
                r_hold2   <= data_in2_muxL1;
                r_hold3   <= data_in3_muxL1;
                r_hold_v2 <= valid_in2;
                r_hold_v3 <= valid_in3;
            end else begin
                r_hold2   <= r_hold2;
                r_hold3   <= r_hold3;
                r_hold_v2 <= r_hold_v2;
                r_hold_v3 <= r_hold_v3;
            end
            r_phase        <= w_nxt_phase;
            selectorL1     <= w_nxt_sel;
            validout0      <= w_nxt_v0;
            validout1      <= w_nxt_v1;
            dataout0_muxL1 <= w_nxt_d0;
            dataout1_muxL1 <= w_nxt_d1;
        end
    end

`ifdef MUXL1_PARITY_EN
    // Parity tracks the value loaded this edge; an invalid slot reports 0
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            parityout0 <= 1'b0;
            parityout1 <= 1'b0;
        end else begin
            parityout0 <= w_nxt_v0 ? parity_f(w_nxt_d0) : 1'b0;
            parityout1 <= w_nxt_v1 ? parity_f(w_nxt_d1) : 1'b0;
        end
    end
`endif

endmodule
